// File: rtl/regfile_mp_sb.sv
`timescale 1ns/1ps
// regfile_mp_sb
// Multi-port integer register file for the RV32IM pipeline with a per-register
// pending scoreboard. Decode reads operands and reserves a destination at
// issue; writeback writes results and releases the matching pending bit.
//
// Ports:
//   CLK       clock, all state updates on the rising edge
//   RESETN    asynchronous active-low reset
//   RADDR     NREAD packed read addresses, port p at [p*AW +: AW]
//   RDATA     NREAD packed read data, port p at [p*XLEN +: XLEN]
//   RBUSY     per read port: addressed register still pending after this cycle's writes
//   WE        per write port enable
//   WADDR     NWRITE packed write addresses
//   WDATA     NWRITE packed write data
//   RSV_EN    reserve request from issue
//   RSV_ADDR  destination register to mark pending
//   PEND_CNT  number of registers currently pending
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic [NREAD*AW-1:0]    RADDR,
    output logic [NREAD*XLEN-1:0]  RDATA,
    output logic [NREAD-1:0]       RBUSY,
    input  logic [NWRITE-1:0]      WE,
    input  logic [NWRITE*AW-1:0]   WADDR,
    input  logic [NWRITE*XLEN-1:0] WDATA,
    input  logic                   RSV_EN,
    input  logic [AW-1:0]          RSV_ADDR,
    output logic [AW:0]            PEND_CNT
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] rsv_mask;
    logic [NREGS-1:0] pend_next;
    logic [AW:0]      cnt_next;

    // Decode which registers are targeted by an active write port and which one
    // is being reserved this cycle. Register 0 is masked out when it is the
    // hard-wired zero so it can never become pending.
    always_comb begin
        wr_hit   = '0;
        rsv_mask = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if (WE[k]) begin
                wr_hit[WADDR[k*AW +: AW]] = 1'b1;
            end
        end
        if (RSV_EN) begin
            rsv_mask[RSV_ADDR] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            wr_hit[0]   = 1'b0;
            rsv_mask[0] = 1'b0;
        end
    end

    // Next pending state: a write releases its target, but a reservation in the
    // same cycle wins because it belongs to the newer producer. The population
    // count is taken from the next state so PEND_CNT moves on the same edge.
    always_comb begin
        pend_next = (pending & ~wr_hit) | rsv_mask;
        cnt_next  = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, pend_next[r]};
        end
    end

    // Register array storage. Ports are visited in ascending order so a
    // higher-indexed port writing the same address overrides a lower one.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (WE[k] && (ZERO_REG == 0 || WADDR[k*AW +: AW] != '0)) begin
                    regs[WADDR[k*AW +: AW]] <= WDATA[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard bits and their registered population count.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pending  <= '0;
            PEND_CNT <= '0;
        end else begin
            pending  <= pend_next;
            PEND_CNT <= cnt_next;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = RADDR[p*AW +: AW];

        // Combinational read with same-cycle forwarding from the write ports.
        // The last matching port wins, mirroring what gets stored at the edge,
        // and a forwarded operand is reported as not busy. Outputs are held at
        // zero while reset is asserted.
        always_comb begin
            rd = regs[ra];
            rb = pending[ra];
            for (int k = 0; k < NWRITE; k++) begin
                if (WE[k] && WADDR[k*AW +: AW] == ra) begin
                    rd = WDATA[k*XLEN +: XLEN];
                    rb = 1'b0;
                end
            end
            if ((ZERO_REG != 0 && ra == '0) || !RESETN) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign RDATA[p*XLEN +: XLEN] = rd;
        assign RBUSY[p]              = rb;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the RV32IM pipeline: NREAD combinational read ports, NWRITE synchronous write ports.
- Write-to-read bypass in the same cycle; optional hard-wired zero register.
- Per-register pending scoreboard: the decode stage reserves a destination at issue; writeback releases it.
- Sits between decode (read/reserve) and writeback (write) and replaces the single-write, two-read register file.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NREAD, 2, number of read ports.
- NWRITE, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- RADDR  in  NREAD*AW  read addresses; port p uses bits [p*AW +: AW].
- RDATA  out  NREAD*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
- RBUSY  out  NREAD  1 = register addressed by port p is pending after this cycle's writes.
- WE  in  NWRITE  write enables.
- WADDR  in  NWRITE*AW  write addresses.
- WDATA  in  NWRITE*XLEN  write data.
- RSV_EN  in  1  reserve request from issue.
- RSV_ADDR  in  AW  destination register to mark pending.
- PEND_CNT  out  AW+1  number of registers currently pending.

Behaviour:
- Reset (RESETN low, asynchronous, no clock needed): all registers = 0, all pending bits = 0, PEND_CNT = 0.
  - RDATA and RBUSY are all 0 while reset is held.
  - Writes and reserves are ignored while reset is held.
  - Release is synchronous to the next CLK edge. Reset in mid-operation discards all writes and reservations in flight.
- Write: on the rising edge, each port k with WE[k]=1 stores WDATA[k] into register WADDR[k].
  - Two ports writing the same address in the same cycle: the higher port index wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Read: purely combinational, zero latency, RDATA[p] = register[RADDR[p]].
  - Bypass: if any WE[k] is active with WADDR[k]==RADDR[p], RDATA[p] = WDATA of the highest such k, i.e. the value that will be stored at the edge.
  - ZERO_REG=1 and RADDR[p]==0: RDATA[p] = 0 regardless of writes.
- Scoreboard: pending[r] is updated on the rising edge.
  - Set to 1 when RSV_EN=1 and RSV_ADDR==r.
  - Otherwise cleared to 0 when any active write port targets r.
  - Otherwise held.
  - Reserve and write to the same r in one cycle: pending ends at 1 (the new producer wins); the data is still written.
  - Reserving an already-pending register: stays 1, no error.
  - ZERO_REG=1: reserve of address 0 is ignored.
- RBUSY[p] = pending[RADDR[p]] AND NOT (an active write targets RADDR[p] this cycle). It reflects the bypass, so a consumer sees "not busy" in the same cycle its operand is forwarded. A reserve in the current cycle does not affect RBUSY until the next cycle.
- PEND_CNT: registered population count of the pending bits; it updates on the same edge as the pending bits and never exceeds NREGS - ZERO_REG.
- Out-of-range addresses cannot occur because NREGS is a power of two.
- No X on any output after reset.

Test Plan:
- Reset then idle: assert RESETN=0 asynchronously mid-cycle -> RDATA=0, RBUSY=0 and PEND_CNT=0 immediately. Read all 32 addresses after release -> 0x00000000.
- Dual write collision: WE=2'b11, WADDR both 5, WDATA0=0x11111111, WDATA1=0x22222222 -> same-cycle RDATA(RADDR=5)=0x22222222; the next-cycle stored value is 0x22222222.
- Zero register: write 0xDEADBEEF to x0 and reserve x0 -> RDATA for x0 = 0, RBUSY=0, PEND_CNT unchanged.
- Scoreboard lifecycle: reserve x7 -> next cycle RBUSY(x7)=1, PEND_CNT=1. Write x7=0xA5A5A5A5 on port 1 -> in that cycle RBUSY=0 and RDATA=0xA5A5A5A5; next cycle pending clear, PEND_CNT=0.
- Reserve and write to the same register in one cycle: x3 pending, write x3=0x5 and reserve x3 in the same cycle -> next cycle RBUSY(x3)=1, RDATA=0x5, PEND_CNT=1.
- Reset mid-stream: reserve x1, x2, x4 and write x9=0x1234, then pulse RESETN low for a quarter cycle -> PEND_CNT=0, x9 reads 0, and a following reserve of x1 counts to 1.
